lcd_line_prefetch: RTL and testbench
====================================

Name: lcd_line_prefetch

Overview:
- Pixel source directly upstream of the LCD timing/output stage.
- Consumes that stage's active-area pixel coordinates x/y and returns R/G/B for each pixel.
- Prefetches the next display line from GPU framebuffer memory into a ping-pong pair of line banks while the current line is scanned out, so the panel never waits on memory.

Parameters:
- H_ACTIVE, 800, pixels per line; bank depth.
- V_ACTIVE, 480, lines per frame; must be even.
- ADDR_W, 20, framebuffer pixel-address width.
- FB_BASE, 0, pixel address of line 0.
- UNDERRUN_RGB, 24'hFF00FF, colour output while the displayed bank is incomplete.

Ports:
- Dclk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- x  in  10  active-area column from the LCD stage.
- y  in  9  active-area row from the LCD stage.
- R  out  8  red for pixel (x,y).
- G  out  8  green for pixel (x,y).
- B  out  8  blue for pixel (x,y).
- req_valid  out  1  line-read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDR_W  first pixel address of requested line.
- rd_valid  in  1  response beat valid; no backpressure.
- rd_data  in  24  response pixel {R,G,B}.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset (reset==0) values:
  - R/G/B = 0; req_valid = 0; req_addr = 0; underrun = 0.
  - FSM = IDLE; both bank_ok flags = 0; y_prev = 0.
  - Any in-progress fill is abandoned.
- Bank mapping: line L is held in bank L[0].
- Output path:
  - R/G/B are registered: one Dclk latency from x/y.
  - Output = bank[y[0]][x] when bank_ok[y[0]]==1.
  - Otherwise output = UNDERRUN_RGB and underrun is set; underrun clears only on reset.
- Line-change detect: y != y_prev (y_prev registered every cycle) queues a fetch of line (y+1) mod V_ACTIVE. Wrap case: y 479→0 fetches line 1.
- Startup sequence after reset release: fetch line 0, then line 1, with no y change required.
- Request address: req_addr = FB_BASE + L*H_ACTIVE, truncated to ADDR_W.
- FSM states:
  - IDLE: a pending fetch exists → clear bank_ok[L[0]], go to REQ.
  - REQ: req_valid=1 with req_addr stable until req_valid&&req_ready; then go to FILL with beat count 0.
  - FILL: each rd_valid writes rd_data to bank[L[0]][count] and increments count. Beat H_ACTIVE-1 sets bank_ok[L[0]] and returns to IDLE.
- rd_valid outside FILL is ignored.
- Pending queue: one-deep.
  - A new line change while busy overwrites the pending line number; the newest request wins.
  - The active fill is never aborted by a line change.
- Simultaneous write and read on the same bank address: the read returns old data; a line is only read after its fill completes.
- The bank is dual-port: write port driven by the fill, read port driven by x/y.

Optional Feature:
- Macro: LCD_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (1 bit).
  - pattern_sel=1 outputs 8 vertical colour bars, bar index = x*8/H_ACTIVE, colours white, yellow, cyan, green, magenta, red, blue, black.
  - Bars keep the same 1-cycle latency, and underrun is not set while pattern_sel=1.
  - Prefetch continues normally.
- When undefined: the port is absent and output always comes from the banks.

Decomposition:
- Package lcd_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults.
  - rgb_t (packed struct of 8-bit r,g,b).
  - fetch_state_t enum {IDLE, REQ, FILL}.
  - Colour-bar constant array.
- Sub-module line_bank_ram: simple dual-port RAM, H_ACTIVE x 24, synchronous read. Instantiated twice.

Test Plan:
- Reset release, memory returns pixel value = address → requests for addr 0 then 800 are issued; both bank_ok flags set after 1600 beats.
- Advance y 0→1 → request addr 1600 (line 2); x=5,y=1 outputs {R,G,B}=805 one cycle later.
- req_ready held low 50 cycles → req_valid and req_addr stay stable; request accepted on the cycle ready rises.
- y steps to 2 while line 2 fill is at beat 100 → R/G/B = FF/00/FF and underrun=1, which persists after the fill completes.
- y 479→0 → request for line 1 (addr 800); line 0 data displayed correctly.
- With LCD_TEST_PATTERN_EN defined, pattern_sel=1, x=0/100/799 → white/yellow/black.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD line prefetcher.
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } fetch_state_t;

  // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t BAR_RGB [0:7] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/line_bank_ram.sv
// One line bank: simple dual-port RAM with a synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module line_bank_ram #(
  parameter int DEPTH = 800,
  parameter int AW    = 10,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write from the fill side, registered read for the display side.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_line_prefetch.sv
// Line prefetcher feeding the LCD output stage. Line L lives in bank L[0];
// while one bank is scanned out the other is refilled from the framebuffer.
// Optional feature macro: LCD_TEST_PATTERN_EN adds pattern_sel (colour bars).
//
// Request handshake: req_valid is high only in REQ and req_addr is held
// constant while req_valid is high; the request transfers on the rising
// Dclk edge where req_valid && req_ready. Response beats (rd_valid) have no
// backpressure and are only consumed in FILL.
module lcd_line_prefetch
  import lcd_pkg::*;
#(
  parameter int          H_ACTIVE     = H_ACTIVE_DEF,
  parameter int          V_ACTIVE     = V_ACTIVE_DEF,
  parameter int          ADDR_W       = 20,
  parameter int          FB_BASE      = 0,
  parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
  input  logic              Dclk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
`ifdef LCD_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rd_valid,
  input  logic [23:0]       rd_data,
  output logic              underrun,
  output fetch_state_t      state_dbg
);

  localparam int CW = $clog2(H_ACTIVE);

  fetch_state_t  state, state_n;
  logic [CW-1:0] count;
  logic [8:0]    cur_line;
  logic [8:0]    pend_line;
  logic          pend_valid;
  logic          boot;
  logic [8:0]    y_prev;
  logic [1:0]    bank_ok;
  logic          line_chg;
  logic [8:0]    next_line;
  logic          take;
  logic          beat;
  logic          last_beat;

  assign state_dbg = state;
  assign line_chg  = (y != y_prev);
  assign next_line = (y == 9'(V_ACTIVE - 1)) ? 9'd0 : y + 9'd1;
  assign take      = (state == IDLE) && pend_valid;
  assign beat      = (state == FILL) && rd_valid;
  assign last_beat = beat && (count == CW'(H_ACTIVE - 1));

  function automatic logic [ADDR_W-1:0] line_addr(input logic [8:0] l);
    line_addr = ADDR_W'(FB_BASE + int'(l) * H_ACTIVE);
  endfunction

  // Fetch FSM state register.
  always_ff @(posedge Dclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Fetch FSM next state and request strobe.
  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    case (state)
      IDLE: if (pend_valid) state_n = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_n = FILL;
      end
      FILL: if (last_beat) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pending line queue, bank validity, request address and beat counter.
  // After reset the queue is preloaded with line 0 and boot chains line 1,
  // so both banks are filled before any y change. A line change always
  // overwrites the pending entry: the newest line wins.
  always_ff @(posedge Dclk or negedge reset) begin
    if (!reset) begin
      y_prev     <= '0;
      pend_valid <= 1'b1;
      pend_line  <= '0;
      boot       <= 1'b1;
      cur_line   <= '0;
      bank_ok    <= '0;
      req_addr   <= '0;
      count      <= '0;
    end else begin
      y_prev <= y;
      if (take) begin
        cur_line             <= pend_line;
        bank_ok[pend_line[0]] <= 1'b0;
        req_addr             <= line_addr(pend_line);
        boot                 <= 1'b0;
      end
      if (line_chg) begin
        pend_valid <= 1'b1;
        pend_line  <= next_line;
      end else if (take) begin
        pend_valid <= boot;
        pend_line  <= 9'd1;
      end
      if (state == REQ && req_ready) count <= '0;
      if (beat) count <= count + 1'b1;
      if (last_beat) bank_ok[cur_line[0]] <= 1'b1;
    end
  end

  logic [23:0] rdata0, rdata1;

  line_bank_ram #(.DEPTH(H_ACTIVE), .AW(CW), .DW(24)) u_bank0 (
    .clk   (Dclk),
    .we    (beat && !cur_line[0]),
    .waddr (count),
    .wdata (rd_data),
    .raddr (CW'(x)),
    .rdata (rdata0)
  );

  line_bank_ram #(.DEPTH(H_ACTIVE), .AW(CW), .DW(24)) u_bank1 (
    .clk   (Dclk),
    .we    (beat && cur_line[0]),
    .waddr (count),
    .wdata (rd_data),
    .raddr (CW'(x)),
    .rdata (rdata1)
  );

  logic out_en, sel_q, ok_q, pat_now;

`ifdef LCD_TEST_PATTERN_EN
  logic       pat_q;
  logic [2:0] bar_q;
  assign pat_now = pattern_sel;

  // Colour-bar selection, registered alongside the bank read.
  always_ff @(posedge Dclk or negedge reset) begin
    if (!reset) begin
      pat_q <= 1'b0;
      bar_q <= '0;
    end else begin
      pat_q <= pattern_sel;
      bar_q <= 3'((32'(x) * 8) / H_ACTIVE);
    end
  end
`else
  assign pat_now = 1'b0;
`endif

  // Output-side registers aligned with the synchronous RAM read; underrun is sticky.
  always_ff @(posedge Dclk or negedge reset) begin
    if (!reset) begin
      out_en   <= 1'b0;
      sel_q    <= 1'b0;
      ok_q     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      out_en   <= 1'b1;
      sel_q    <= y[0];
      ok_q     <= bank_ok[y[0]];
      underrun <= underrun | (~bank_ok[y[0]] & ~pat_now);
    end
  end

  rgb_t rgb;

  // Pixel select from the registered read data; zero until the first edge after reset.
  always_comb begin
    rgb = '0;
    if (out_en) begin
`ifdef LCD_TEST_PATTERN_EN
      if (pat_q)      rgb = BAR_RGB[bar_q];
      else if (!ok_q) rgb = UNDERRUN_RGB;
      else            rgb = sel_q ? rdata1 : rdata0;
`else
      if (!ok_q) rgb = UNDERRUN_RGB;
      else       rgb = sel_q ? rdata1 : rdata0;
`endif
    end
  end

  assign R = rgb.r;
  assign G = rgb.g;
  assign B = rgb.b;

endmodule

// File: tb/tb_lcd_line_prefetch.sv
// Directed bench for lcd_line_prefetch with a framebuffer model whose pixel
// value equals its address.
module tb_lcd_line_prefetch;
  import lcd_pkg::*;

  // clock / reset
  logic Dclk = 1'b0;
  always #5 Dclk = ~Dclk;

  logic         reset;
  logic [9:0]   x;
  logic [8:0]   y;
  logic [7:0]   R, G, B;
  logic         req_valid, req_ready;
  logic [19:0]  req_addr;
  logic         rd_valid;
  logic [23:0]  rd_data;
  logic         underrun;
  fetch_state_t state_dbg;
`ifdef LCD_TEST_PATTERN_EN
  logic         pattern_sel;
`endif

  lcd_line_prefetch dut (
    .Dclk      (Dclk),
    .reset     (reset),
    .x         (x),
    .y         (y),
`ifdef LCD_TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .R         (R),
    .G         (G),
    .B         (B),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .underrun  (underrun),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];
  logic [19:0] act_q[$];

  int          fills_done = 0;
  int          beat_no    = 0;
  bit          busy       = 1'b0;
  logic [19:0] cur_base   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory model: accept a request on the edge, then stream 800 beats of addr+i
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge Dclk);
      if (!busy && reset && req_valid && req_ready) begin
        act_q.push_back(req_addr);
        busy     = 1'b1;
        beat_no  = 0;
        cur_base = req_addr;
      end
      @(negedge Dclk);
      if (busy) begin
        if (beat_no < 800) begin
          rd_valid = 1'b1;
          rd_data  = 24'(cur_base) + 24'(beat_no);
          beat_no++;
        end else begin
          rd_valid = 1'b0;
          busy     = 1'b0;
          fills_done++;
        end
      end else begin
        rd_valid = 1'b0;
      end
    end
  end

  task automatic wait_fills(input int n);
    int t = 0;
    while (fills_done < n && t < 5000) begin
      @(negedge Dclk);
      t++;
    end
    check_eq("fills_done", 32'(fills_done), 32'(n));
  endtask

  task automatic check_req(input string tag);
    logic [31:0] got, exp;
    got = (act_q.size() > 0) ? 32'(act_q.pop_front()) : 32'hFFFF_FFFF;
    exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hEEEE_EEEE;
    check_eq(tag, got, exp);
  endtask

  task automatic wait_fill_state();
    int t = 0;
    while (state_dbg !== FILL && t < 200) begin
      @(negedge Dclk);
      t++;
    end
    check_eq("reach_fill", 32'(state_dbg), 32'(FILL));
  endtask

  // stimulus
  initial begin
    bit bad;
    int t;
    reset     = 1'b0;
    x         = '0;
    y         = '0;
    req_ready = 1'b1;
`ifdef LCD_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    repeat (3) @(negedge Dclk);
    check_eq("rst_rgb", {R, G, B}, 24'h0);
    check_eq("rst_req_valid", req_valid, 1'b0);
    check_eq("rst_req_addr", req_addr, 20'h0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));

    // startup: lines 0 and 1 without any y change
    reset = 1'b1;
    exp_q.push_back(20'd0);
    exp_q.push_back(20'd800);
    wait_fills(2);
    @(negedge Dclk);
    check_req("boot_req0");
    check_req("boot_req1");
    check_eq("boot_idle", 32'(state_dbg), 32'(IDLE));
    check_eq("boot_no_req", req_valid, 1'b0);
    // y=0 was displayed before bank 0 filled, so the sticky flag is already set
    check_eq("boot_underrun", underrun, 1'b1);

    x = 10'd5;
    @(negedge Dclk);
    check_eq("pix_0_5", {R, G, B}, 24'd5);
    x = 10'd799;
    @(negedge Dclk);
    check_eq("pix_0_799", {R, G, B}, 24'd799);

    // y 0->1 fetches line 2
    x = 10'd5;
    y = 9'd1;
    exp_q.push_back(20'd1600);
    @(negedge Dclk);
    check_eq("pix_1_5", {R, G, B}, 24'd805);
    wait_fills(3);
    @(negedge Dclk);
    check_req("line2_req");
    check_eq("pix_1_5_again", {R, G, B}, 24'd805);

    // request held while ready is low
    req_ready = 1'b0;
    y = 9'd2;
    exp_q.push_back(20'd2400);
    @(negedge Dclk);
    check_eq("pix_2_5", {R, G, B}, 24'd1605);
    repeat (2) @(negedge Dclk);
    bad = 1'b0;
    repeat (50) begin
      @(negedge Dclk);
      if (req_valid !== 1'b1 || req_addr !== 20'd2400) bad = 1'b1;
    end
    check_eq("req_hold", bad, 1'b0);
    check_eq("req_state", 32'(state_dbg), 32'(REQ));
    req_ready = 1'b1;
    @(negedge Dclk);
    check_eq("req_accept_state", 32'(state_dbg), 32'(FILL));
    check_eq("req_accept_valid", req_valid, 1'b0);
    wait_fills(4);
    check_req("line3_req");

    // step onto a line whose bank is mid-fill
    y = 9'd3;
    exp_q.push_back(20'd3200);
    @(negedge Dclk);
    check_eq("pix_3_5", {R, G, B}, 24'd2405);
    t = 0;
    while (!(busy && beat_no >= 100) && t < 500) begin
      @(negedge Dclk);
      t++;
    end
    y = 9'd4;
    exp_q.push_back(20'd4000);
    @(negedge Dclk);
    check_eq("underrun_rgb", {R, G, B}, 24'hFF00FF);
    check_eq("underrun_flag", underrun, 1'b1);
    wait_fills(5);
    @(negedge Dclk);
    check_eq("pix_4_5", {R, G, B}, 24'd3205);
    check_req("line4_req");
    wait_fills(6);
    check_req("line5_req");
    check_eq("underrun_sticky", underrun, 1'b1);

    // frame wrap: 479 fetches line 0, 0 fetches line 1
    y = 9'd479;
    exp_q.push_back(20'd0);
    wait_fills(7);
    check_req("wrap_line0_req");
    x = 10'd7;
    y = 9'd0;
    exp_q.push_back(20'd800);
    @(negedge Dclk);
    check_eq("pix_0_7", {R, G, B}, 24'd7);
    wait_fills(8);
    check_req("wrap_line1_req");

    // pending overwrite: newest line change wins while a fill runs
    y = 9'd10;
    exp_q.push_back(20'd8800);
    wait_fill_state();
    y = 9'd20;
    @(negedge Dclk);
    y = 9'd30;
    exp_q.push_back(20'd24800);
    @(negedge Dclk);
    wait_fills(10);
    check_req("ovw_line11_req");
    check_req("ovw_line31_req");

`ifdef LCD_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    x = 10'd0;
    @(negedge Dclk);
    check_eq("bar_white", {R, G, B}, 24'hFFFFFF);
    x = 10'd100;
    @(negedge Dclk);
    check_eq("bar_yellow", {R, G, B}, 24'hFFFF00);
    x = 10'd799;
    @(negedge Dclk);
    check_eq("bar_black", {R, G, B}, 24'h000000);
    pattern_sel = 1'b0;
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
